// File: rtl/conversor_bcd_produto.sv
// Converts the multiplier's binary product to three BCD digits with sequential
// double-dabble and drives three 7-segment displays with leading-zero blanking.
module conversor_bcd_produto #(
    parameter int LARGURA         = 8,
    parameter bit SEG_ATIVO_BAIXO = 1'b1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [LARGURA-1:0] Produto,
    input  logic               Done,
    output logic [3:0]         Centena,
    output logic [3:0]         Dezena,
    output logic [3:0]         Unidade,
    output logic [6:0]         Hex2,
    output logic [6:0]         Hex1,
    output logic [6:0]         Hex0,
    output logic               Pronto,
    output logic               Ocupado,
    output logic               Descartado
);

    localparam logic [6:0] SEG_INV     = SEG_ATIVO_BAIXO ? 7'h00 : 7'h7F;
    localparam logic [6:0] SEG_APAGADO = 7'h7F ^ SEG_INV;

    typedef enum logic [1:0] {OCIOSO, DESLOCA, FIM} estado_t;

    estado_t            r_estado, w_prox;
    logic               r_done_d;
    logic               w_req;
    logic               w_ocupado;
    logic [LARGURA-1:0] r_desl;
    logic [11:0]        r_bcd;
    logic [11:0]        w_bcd_aj;
    logic [3:0]         r_cont;
    logic [3:0]         r_cen, r_dez, r_uni;
    logic [6:0]         r_hex2, r_hex1, r_hex0;
    logic               r_pronto;
    logic               r_descartado;

    function automatic logic [6:0] seg7(input logic [3:0] d, input logic apaga);
        logic [6:0] s;
        if (apaga) begin
            s = 7'h7F;
        end else begin
            case (d)
                4'd0:    s = 7'h40;
                4'd1:    s = 7'h79;
                4'd2:    s = 7'h24;
                4'd3:    s = 7'h30;
                4'd4:    s = 7'h19;
                4'd5:    s = 7'h12;
                4'd6:    s = 7'h02;
                4'd7:    s = 7'h78;
                4'd8:    s = 7'h00;
                4'd9:    s = 7'h10;
                default: s = 7'h7F;
            endcase
        end
        return s ^ SEG_INV;
    endfunction

    assign w_req = Done & ~r_done_d;

    always_comb begin
        w_bcd_aj = r_bcd;
        for (int unsigned i = 0; i < 3; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_bcd_aj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) r_estado <= OCIOSO;
        else       r_estado <= w_prox;
    end

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            OCIOSO:  if (w_req) w_prox = DESLOCA;
            DESLOCA: if (r_cont == 4'd1) w_prox = FIM;
            FIM:     w_prox = OCIOSO;
            default: w_prox = OCIOSO;
        endcase
    end

    always_comb begin
        w_ocupado = (r_estado != OCIOSO);
    end

    // FIM still counts as busy, so a request landing on the return edge is dropped
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_done_d     <= 1'b0;
            r_desl       <= '0;
            r_bcd        <= '0;
            r_cont       <= '0;
            r_cen        <= '0;
            r_dez        <= '0;
            r_uni        <= '0;
            r_hex2       <= SEG_APAGADO;
            r_hex1       <= SEG_APAGADO;
            r_hex0       <= SEG_APAGADO;
            r_pronto     <= 1'b0;
            r_descartado <= 1'b0;
        end else begin
            r_done_d     <= Done;
            r_pronto     <= 1'b0;
            r_descartado <= w_req & w_ocupado;
            case (r_estado)
                OCIOSO: begin
                    if (w_req) begin
                        r_desl <= Produto;
                        r_bcd  <= '0;
                        r_cont <= 4'(LARGURA);
                    end
                end
                DESLOCA: begin
                    r_bcd  <= {w_bcd_aj[10:0], r_desl[LARGURA-1]};
                    r_desl <= r_desl << 1;
                    r_cont <= r_cont - 4'd1;
                end
                FIM: begin
                    r_cen    <= r_bcd[11:8];
                    r_dez    <= r_bcd[7:4];
                    r_uni    <= r_bcd[3:0];
                    r_hex2   <= seg7(r_bcd[11:8], r_bcd[11:8] == 4'd0);
                    r_hex1   <= seg7(r_bcd[7:4], r_bcd[11:4] == 8'd0);
                    r_hex0   <= seg7(r_bcd[3:0], 1'b0);
                    r_pronto <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Centena    = r_cen;
    assign Dezena     = r_dez;
    assign Unidade    = r_uni;
    assign Hex2       = r_hex2;
    assign Hex1       = r_hex1;
    assign Hex0       = r_hex0;
    assign Pronto     = r_pronto;
    assign Ocupado    = w_ocupado;
    assign Descartado = r_descartado;

endmodule

// File: tb/tb_conversor_bcd_produto.sv
// Bench for conversor_bcd_produto: vector table plus scoreboard of expected
// conversions popped on each Pronto, with hand sequences for busy/reset cases.
module tb_conversor_bcd_produto;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] Produto;
    logic       Done;
    logic [3:0] Centena, Dezena, Unidade;
    logic [6:0] Hex2, Hex1, Hex0;
    logic       Pronto, Ocupado, Descartado;

    conversor_bcd_produto #(
        .LARGURA(8),
        .SEG_ATIVO_BAIXO(1'b1)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Produto(Produto), .Done(Done),
        .Centena(Centena), .Dezena(Dezena), .Unidade(Unidade),
        .Hex2(Hex2), .Hex1(Hex1), .Hex0(Hex0),
        .Pronto(Pronto), .Ocupado(Ocupado), .Descartado(Descartado)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int         produto;
        logic [3:0] c, d, u;
        logic [6:0] h2, h1, h0;
    } vec_t;

    typedef struct {
        vec_t v;
        int   due;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_pronto = 0;
    int   n_desc = 0;
    int   n_ocup = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic vec_t modelo(input int p);
        vec_t v;
        int c, d, u;
        c = p / 100;
        d = (p / 10) % 10;
        u = p % 10;
        v.produto = p;
        v.c  = 4'(c);
        v.d  = 4'(d);
        v.u  = 4'(u);
        v.h2 = (c == 0) ? 7'h7F : seg_ref(c);
        v.h1 = (c == 0 && d == 0) ? 7'h7F : seg_ref(d);
        v.h0 = seg_ref(u);
        return v;
    endfunction

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (Descartado) n_desc++;
        if (Ocupado)    n_ocup++;
        if (Pronto) begin
            n_pronto++;
            if (q.size() == 0) begin
                chk("pronto_inesperado", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("centena", int'(Centena), int'(e.v.c));
                chk("dezena",  int'(Dezena),  int'(e.v.d));
                chk("unidade", int'(Unidade), int'(e.v.u));
                chk("hex2",    int'(Hex2),    int'(e.v.h2));
                chk("hex1",    int'(Hex1),    int'(e.v.h1));
                chk("hex0",    int'(Hex0),    int'(e.v.h0));
                chk("latencia", cyc, e.due);
            end
        end
    end

    // Called at a negedge: the next posedge is the capture edge E0
    task automatic pedir(input vec_t v, input bit esperado);
        exp_t e;
        Produto = 8'(v.produto);
        Done    = 1'b1;
        if (esperado) begin
            e.v   = v;
            e.due = cyc + 10;
            q.push_back(e);
        end
        @(negedge Clk);
        Done = 1'b0;
    endtask

    task automatic esvaziar();
        for (int n = 0; n < 40 && q.size() != 0; n++) @(negedge Clk);
        chk("scoreboard_vazio", q.size(), 0);
        repeat (2) @(negedge Clk);
    endtask

    task automatic ciclos(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_centena"}, int'(Centena), 0);
        chk({nm, "_dezena"},  int'(Dezena),  0);
        chk({nm, "_unidade"}, int'(Unidade), 0);
        chk({nm, "_hex2"},    int'(Hex2),    'h7F);
        chk({nm, "_hex1"},    int'(Hex1),    'h7F);
        chk({nm, "_hex0"},    int'(Hex0),    'h7F);
        chk({nm, "_pronto"},  int'(Pronto),  0);
        chk({nm, "_ocupado"}, int'(Ocupado), 0);
        chk({nm, "_descart"}, int'(Descartado), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab[10];
        int   b_pr, b_ds, b_oc;

        tab[0] = '{143, 4'd1, 4'd4, 4'd3, 7'h79, 7'h19, 7'h30};
        tab[1] = '{225, 4'd2, 4'd2, 4'd5, 7'h24, 7'h24, 7'h12};
        tab[2] = '{0,   4'd0, 4'd0, 4'd0, 7'h7F, 7'h7F, 7'h40};
        tab[3] = '{7,   4'd0, 4'd0, 4'd7, 7'h7F, 7'h7F, 7'h78};
        tab[4] = '{60,  4'd0, 4'd6, 4'd0, 7'h7F, 7'h02, 7'h40};
        tab[5] = '{255, 4'd2, 4'd5, 4'd5, 7'h24, 7'h12, 7'h12};
        tab[6] = '{100, 4'd1, 4'd0, 4'd0, 7'h79, 7'h40, 7'h40};
        tab[7] = '{9,   4'd0, 4'd0, 4'd9, 7'h7F, 7'h7F, 7'h10};
        tab[8] = '{10,  4'd0, 4'd1, 4'd0, 7'h7F, 7'h79, 7'h40};
        tab[9] = '{99,  4'd0, 4'd9, 4'd9, 7'h7F, 7'h10, 7'h10};

        Reset = 1'b1;
        Done = 1'b0;
        Produto = '0;
        ciclos(3);
        chk_reset("reset");
        Reset = 1'b0;
        ciclos(2);

        // Isolated conversions from the table
        b_ds = n_desc;
        for (int i = 0; i < 9; i++) begin
            pedir(tab[i], 1'b1);
            esvaziar();
        end
        chk("tabela_descartado", n_desc - b_ds, 0);

        // Done held high: one request only
        b_pr = n_pronto;
        b_ds = n_desc;
        begin
            exp_t e;
            Produto = 8'd99;
            Done = 1'b1;
            e.v = tab[9];
            e.due = cyc + 10;
            q.push_back(e);
            ciclos(30);
            Done = 1'b0;
        end
        esvaziar();
        chk("done_alto_pronto", n_pronto - b_pr, 1);
        chk("done_alto_descart", n_desc - b_ds, 0);

        // Second rising edge while busy is dropped; Produto change ignored
        b_ds = n_desc;
        b_oc = n_ocup;
        pedir(tab[0], 1'b1);
        Produto = 8'd200;
        ciclos(2);
        Done = 1'b1;
        ciclos(1);
        Done = 1'b0;
        esvaziar();
        ciclos(3);
        chk("ocupado_ciclos", n_ocup - b_oc, 9);
        chk("descartado_pulso", n_desc - b_ds, 1);

        // Reset four cycles into a conversion aborts it
        b_pr = n_pronto;
        pedir(tab[0], 1'b0);
        ciclos(3);
        Reset = 1'b1;
        ciclos(1);
        chk_reset("reset_meio");
        ciclos(1);
        Reset = 1'b0;
        ciclos(12);
        chk("aborto_sem_pronto", n_pronto - b_pr, 0);
        chk("aborto_hex0", int'(Hex0), 'h7F);
        pedir(modelo(81), 1'b1);
        esvaziar();

        // Full 4x4 product sweep at 12-cycle spacing
        b_ds = n_desc;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                pedir(modelo(i * j), 1'b1);
                ciclos(11);
            end
        end
        esvaziar();
        chk("varredura_descart", n_desc - b_ds, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conversor_bcd_produto.md
Name: conversor_bcd_produto

Overview:
Downstream stage of the 4x4 shift-add multiplier: consumes Produto/Done and converts the binary product to three BCD digits using sequential double-dabble (shift-add-3). Drives three 7-segment displays with leading-zero blanking. Holds the last result until the next conversion completes.

Parameters:
LARGURA, 8, width of Produto input; legal range 1..9, because three digits hold at most 999.
SEG_ATIVO_BAIXO, 1, 1 = segments active-low, 0 = active-high; inverts every Hex output, including blank.

Ports:
Clk  input  1  system clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
Produto  input  LARGURA  binary product from multiplier; sampled only on the capture edge.
Done  input  1  multiplier done flag, level; a 0->1 transition requests conversion.
Centena  output  4  BCD hundreds digit.
Dezena  output  4  BCD tens digit.
Unidade  output  4  BCD units digit.
Hex2  output  7  segments for hundreds, bit order gfedcba.
Hex1  output  7  segments for tens, bit order gfedcba.
Hex0  output  7  segments for units, bit order gfedcba.
Pronto  output  1  one-cycle pulse: new result valid on the digit and Hex outputs.
Ocupado  output  1  high while a conversion is in progress.
Descartado  output  1  one-cycle pulse: a Done rising edge arrived while busy and was dropped.

Behaviour:
- Done_d: register holding the previous Done. Request = Done & ~Done_d. Reset clears Done_d.
- FSM states: OCIOSO, DESLOCA, FIM. Reset state is OCIOSO.
- OCIOSO:
  - On Request, latch Produto into the shift register, clear the BCD accumulator, set counter = LARGURA, go to DESLOCA.
  - Otherwise remain in OCIOSO.
- DESLOCA, one bit per clock:
  - Each BCD nibble >= 5 gets +3.
  - Then the {BCD, shift} concatenation shifts left by 1 and the counter decrements.
  - When the counter reaches 0 after the shift, go to FIM.
- FIM: copy the BCD accumulator to Centena/Dezena/Unidade and the Hex registers, assert Pronto for one cycle, return to OCIOSO.
- Latency: capture edge E0; shift edges E1..E(LARGURA); output edge E(LARGURA+1). Pronto is high for exactly the cycle after E(LARGURA+1), which is 9 clocks after capture for LARGURA=8. Back-to-back conversions need at least LARGURA+2 cycles between requests.
- Ocupado = 1 in DESLOCA and FIM; 0 in OCIOSO.
- Request while Ocupado: the request is ignored and Descartado pulses for 1 cycle. The current conversion and outputs are unaffected.
- Request in the same cycle that FIM returns to OCIOSO: treated as busy and dropped with Descartado.
- Done held high: only one Request is generated per 0->1 transition.
- Outputs are registered and change only at the FIM edge; Produto changes mid-conversion have no effect.
- Active-low digit encoding:
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19.
  - 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
  - blank=0x7F.
  - With SEG_ATIVO_BAIXO=0, every value is the bitwise complement.
- Leading-zero blanking:
  - Hex2 blank when Centena=0.
  - Hex1 blank when Centena=0 and Dezena=0.
  - Hex0 is never blank after the first conversion.
- Reset, including mid-conversion:
  - State goes to OCIOSO.
  - Digits = 0.
  - Hex2/Hex1/Hex0 = blank (all segments off).
  - Pronto, Ocupado and Descartado = 0.
  - The in-flight conversion is aborted with no Pronto.
  - The first Request after Reset deasserts converts normally.
- BCD nibbles never exceed 9 for LARGURA<=9. Centena is always 0 when LARGURA<=6.

Test Plan:
1. Produto=143 (13x11), Done 0->1 -> after 9 clocks Pronto pulses once; Centena/Dezena/Unidade=1/4/3; Hex2/Hex1/Hex0=0x79/0x19/0x30.
2. Produto=225 (15x15) -> digits 2/2/5; Hex 0x24/0x24/0x12. Then Produto=0 -> digits 0/0/0; Hex2=0x7F, Hex1=0x7F, Hex0=0x40.
3. Produto=7 -> Hex2 and Hex1 blank, Hex0=0x78. Produto=60 -> Hex2 blank, Hex1=0x02, Hex0=0x40.
4. Done held high 30 cycles with Produto=99 -> exactly one Pronto; digits 0/9/9; no Descartado.
5. Second Done rising edge 3 cycles after the first (Produto changed to 200) -> Descartado pulses one cycle; result is the first product; Ocupado stays high for 9 cycles.
6. Reset asserted 4 cycles into a conversion of 143 -> no Pronto; digits 0; Hex all 0x7F. Then a new request with 81 -> 0/8/1 after 9 clocks.
7. Sweep all 256 products i*j, i,j in 0..15, each spaced 12 cycles apart -> every result matches decimal i*j; no Descartado.
